// File: rtl/jlsemi_util_clkdiv_pkg.sv
// jlsemi_util_clkdiv_pkg: shared state encoding, ratio limits and defaults for the clock-divider config sequencer
package jlsemi_util_clkdiv_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GATE   = 3'd1;
  localparam logic [2:0] S_RST    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [3:0] RATIO_MIN = 4'd3;
  localparam logic [3:0] RATIO_MAX = 4'd15;
  localparam logic [3:0] DEF_RATIO = 4'd3;
  localparam logic [1:0] DEF_PHASE = 2'd0;
endpackage

// File: rtl/jlsemi_util_clkdiv_cfg_chk.sv
// jlsemi_util_clkdiv_cfg_chk: combinational validity check of a requested divider configuration
module jlsemi_util_clkdiv_cfg_chk
  import jlsemi_util_clkdiv_pkg::*;
(
  input  logic [3:0] ratio,
  input  logic [1:0] phase,
  output logic       valid
);
  assign valid = ratio[0] && (ratio >= RATIO_MIN) && ({1'b0, ratio} <= {1'b0, RATIO_MAX})
                 && ({2'b00, phase} < ratio);
endmodule

// File: rtl/jlsemi_util_clkdiv_cfg_seq.sv
// jlsemi_util_clkdiv_cfg_seq: gates the divided clock, resets the odd divider with a new ratio/phase, waits to settle, then re-enables
module jlsemi_util_clkdiv_cfg_seq
  import jlsemi_util_clkdiv_pkg::*;
#(
  parameter int unsigned GATE_DLY    = 4,
  parameter int unsigned RST_CYC     = 3,
  parameter int unsigned SETTLE_MULT = 2
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       cfg_req,
  input  logic [3:0] cfg_div_ratio,
  input  logic [1:0] cfg_phase,
  input  logic       dft_clkdiv_rstn_ctrl,
  input  logic       dft_clkdiv_scan_rstn,
  output logic [3:0] div_ratio,
  output logic [1:0] div_phase,
  output logic       div_rstn,
  output logic       clk_gate_en,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err
);
  logic [2:0] state;
  logic [7:0] cnt;
  logic [3:0] cap_ratio;
  logic [1:0] cap_phase;
  logic       req_ok;
  logic       cnt_zero;
  logic [7:0] settle_len;
  jlsemi_util_clkdiv_cfg_chk u_chk (
    .ratio(cfg_div_ratio),
    .phase(cfg_phase),
    .valid(req_ok)
  );
  assign cnt_zero   = cnt == 8'd0;
  assign settle_len = 8'(SETTLE_MULT) * {4'd0, div_ratio} - 8'd1;
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state     <= S_RST;
      cnt       <= 8'(RST_CYC - 1);
      div_ratio <= DEF_RATIO;
      div_phase <= DEF_PHASE;
      cap_ratio <= DEF_RATIO;
      cap_phase <= DEF_PHASE;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_req && !(state == S_IDLE && req_ok);
      case (state)
        S_IDLE: if (cfg_req && req_ok) begin
          state     <= S_GATE;
          cnt       <= 8'(GATE_DLY - 1);
          cap_ratio <= cfg_div_ratio;
          cap_phase <= cfg_phase;
        end
        S_GATE: if (cnt_zero) begin
          state     <= S_RST;
          cnt       <= 8'(RST_CYC - 1);
          div_ratio <= cap_ratio;
          div_phase <= cap_phase;
        end else cnt <= cnt - 8'd1;
        // div_ratio already holds the new ratio here, so the settle length tracks it
        S_RST: if (cnt_zero) begin
          state <= S_SETTLE;
          cnt   <= settle_len;
        end else cnt <= cnt - 8'd1;
        S_SETTLE: if (cnt_zero) state <= S_DONE;
          else cnt <= cnt - 8'd1;
        default: state <= S_IDLE;
      endcase
    end
  end
  assign div_rstn    = dft_clkdiv_rstn_ctrl ? dft_clkdiv_scan_rstn : (state != S_RST);
  assign clk_gate_en = (state == S_IDLE) || (state == S_DONE);
  assign cfg_busy    = state != S_IDLE;
  assign cfg_done    = state == S_DONE;
endmodule

// File: tb/tb_jlsemi_util_clkdiv_cfg_seq.sv
// tb_jlsemi_util_clkdiv_cfg_seq: directed scenarios with hand-computed cycle timing for the config sequencer
module tb_jlsemi_util_clkdiv_cfg_seq;
  logic       clk_in = 1'b0;
  logic       rstn_in = 1'b0;
  logic       cfg_req = 1'b0;
  logic [3:0] cfg_div_ratio = 4'd3;
  logic [1:0] cfg_phase = 2'd0;
  logic       dft_clkdiv_rstn_ctrl = 1'b0;
  logic       dft_clkdiv_scan_rstn = 1'b0;
  logic [3:0] div_ratio;
  logic [1:0] div_phase;
  logic       div_rstn, clk_gate_en, cfg_busy, cfg_done, cfg_err;
  int errors = 0;
  int checks = 0;
  jlsemi_util_clkdiv_cfg_seq dut (
    .clk_in(clk_in),
    .rstn_in(rstn_in),
    .cfg_req(cfg_req),
    .cfg_div_ratio(cfg_div_ratio),
    .cfg_phase(cfg_phase),
    .dft_clkdiv_rstn_ctrl(dft_clkdiv_rstn_ctrl),
    .dft_clkdiv_scan_rstn(dft_clkdiv_scan_rstn),
    .div_ratio(div_ratio),
    .div_phase(div_phase),
    .div_rstn(div_rstn),
    .clk_gate_en(clk_gate_en),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err)
  );
  always #5 clk_in = ~clk_in;
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  // reset released before edge 1: RST for 3 cycles, SETTLE for 6, DONE after edge 9
  task automatic check_bringup;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({cfg_done, clk_gate_en, div_rstn, cfg_busy, div_ratio, div_phase} !==
          {1'(k == 9), 1'(k >= 9), 1'(k >= 3), 1'(k <= 9), 4'd3, 2'd0}) begin
        errors++;
        $display("FAIL bringup k=%0d got done=%b gate=%b rstn=%b busy=%b ratio=%0d phase=%0d", k,
                 cfg_done, clk_gate_en, div_rstn, cfg_busy, div_ratio, div_phase);
      end
    end
  endtask
  task automatic test_reset;
    rstn_in = 1'b0;
    #12;
    checks++;
    if ({div_ratio, div_phase, div_rstn, clk_gate_en, cfg_busy, cfg_done, cfg_err} !==
        {4'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got ratio=%0d phase=%0d rstn=%b gate=%b busy=%b done=%b err=%b want 3 0 0 0 1 0 0",
               div_ratio, div_phase, div_rstn, clk_gate_en, cfg_busy, cfg_done, cfg_err);
    end
    @(negedge clk_in);
    rstn_in = 1'b1;
    check_bringup();
  endtask
  // cfg_done at N+1+4+3+2*r
  task automatic run_seq(input logic [3:0] r, input logic [1:0] p, input logic [3:0] pr,
                         input logic [1:0] pp);
    int dn;
    dn = 8 + 2 * int'(r);
    cfg_div_ratio = r;
    cfg_phase = p;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    cfg_div_ratio = 4'd9;
    cfg_phase = 2'd2;
    for (int t = 1; t <= dn + 1; t++) begin
      checks++;
      if ({clk_gate_en, div_rstn, cfg_done, cfg_busy, cfg_err, div_ratio, div_phase} !==
          {1'(t >= dn), 1'(t < 5 || t > 7), 1'(t == dn), 1'(t <= dn), 1'b0,
           (t >= 5) ? r : pr, (t >= 5) ? p : pp}) begin
        errors++;
        $display("FAIL seq r=%0d t=%0d got gate=%b rstn=%b done=%b busy=%b err=%b ratio=%0d phase=%0d",
                 r, t, clk_gate_en, div_rstn, cfg_done, cfg_busy, cfg_err, div_ratio, div_phase);
      end
      tick();
    end
  endtask
  task automatic test_config;
    run_seq(4'd5, 2'd1, 4'd3, 2'd0);
  endtask
  task automatic test_invalid;
    logic [3:0] rs [3] = '{4'd4, 4'd1, 4'd3};
    logic [1:0] ps [3] = '{2'd0, 2'd0, 2'd3};
    for (int i = 0; i < 3; i++) begin
      cfg_div_ratio = rs[i];
      cfg_phase = ps[i];
      cfg_req = 1'b1;
      tick();
      cfg_req = 1'b0;
      checks++;
      if ({cfg_err, cfg_busy, clk_gate_en, div_rstn, cfg_done, div_ratio, div_phase} !==
          {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 2'd1}) begin
        errors++;
        $display("FAIL invalid_%0d got err=%b busy=%b gate=%b rstn=%b done=%b ratio=%0d phase=%0d want 1 0 1 1 0 5 1",
                 i, cfg_err, cfg_busy, clk_gate_en, div_rstn, cfg_done, div_ratio, div_phase);
      end
      tick();
      checks++;
      if ({cfg_err, cfg_busy, div_ratio} !== {1'b0, 1'b0, 4'd5}) begin
        errors++;
        $display("FAIL invalid_after_%0d got err=%b busy=%b ratio=%0d want 0 0 5", i, cfg_err,
                 cfg_busy, div_ratio);
      end
    end
  endtask
  // ratio=3: DONE at N+14; extra requests at N+10 and N+14
  task automatic test_back_to_back;
    cfg_div_ratio = 4'd3;
    cfg_phase = 2'd2;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    for (int t = 1; t <= 17; t++) begin
      checks++;
      if ({cfg_err, cfg_done, cfg_busy, div_ratio, div_phase} !==
          {1'(t == 11 || t == 15), 1'(t == 14), 1'(t <= 14), (t >= 5) ? 4'd3 : 4'd5,
           (t >= 5) ? 2'd2 : 2'd1}) begin
        errors++;
        $display("FAIL b2b t=%0d got err=%b done=%b busy=%b ratio=%0d phase=%0d", t, cfg_err,
                 cfg_done, cfg_busy, div_ratio, div_phase);
      end
      cfg_req = (t == 10 || t == 14);
      cfg_div_ratio = 4'd7;
      cfg_phase = 2'd0;
      tick();
    end
    cfg_req = 1'b0;
  endtask
  task automatic test_reset_mid;
    cfg_div_ratio = 4'd7;
    cfg_phase = 2'd0;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    for (int t = 1; t < 6; t++) tick();
    checks++;
    if ({div_ratio, div_rstn, cfg_busy} !== {4'd7, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_before got ratio=%0d rstn=%b busy=%b want 7 0 1", div_ratio, div_rstn,
               cfg_busy);
    end
    #2;
    rstn_in = 1'b0;
    #1;
    checks++;
    if ({div_ratio, div_phase, div_rstn, clk_gate_en, cfg_busy, cfg_done, cfg_err} !==
        {4'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got ratio=%0d phase=%0d rstn=%b gate=%b busy=%b done=%b err=%b",
               div_ratio, div_phase, div_rstn, clk_gate_en, cfg_busy, cfg_done, cfg_err);
    end
    tick();
    @(negedge clk_in);
    rstn_in = 1'b1;
    check_bringup();
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if ({cfg_busy, clk_gate_en, div_ratio} !== {1'b0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL mid_discard got busy=%b gate=%b ratio=%0d want 0 1 3", cfg_busy, clk_gate_en,
               div_ratio);
    end
  endtask
  task automatic test_dft;
    dft_clkdiv_rstn_ctrl = 1'b1;
    cfg_div_ratio = 4'd3;
    cfg_phase = 2'd1;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      dft_clkdiv_scan_rstn = 1'(t % 2);
      #1;
      checks++;
      if ({div_rstn, cfg_done, clk_gate_en} !== {1'(t % 2), 1'(t == 14), 1'(t >= 14)}) begin
        errors++;
        $display("FAIL dft t=%0d got rstn=%b done=%b gate=%b", t, div_rstn, cfg_done, clk_gate_en);
      end
      tick();
    end
    dft_clkdiv_rstn_ctrl = 1'b0;
    dft_clkdiv_scan_rstn = 1'b0;
    #1;
    checks++;
    if ({div_rstn, div_phase} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL dft_release got rstn=%b phase=%0d want 1 1", div_rstn, div_phase);
    end
  endtask
  initial begin
    test_reset();
    test_config();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_dft();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
